// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter: per-master grant, owner index and lock qualifier.
// Latency: grant/owner change registered on the hclk edge that accepts the deciding beat.
// Backpressure: hready=0 freezes all state, so grant is stable through wait states.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int MW             = 2,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_TENURE     = 16
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MW-1:0]          hmaster,
  output logic                   hmastlock
);

  localparam int TW = $clog2(MAX_TENURE + 1);

  localparam logic [1:0] ST_PARK   = 2'd0;
  localparam logic [1:0] ST_OWNED  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [2:0] BU_INCR   = 3'b001;

  localparam logic [MW-1:0]          DEF_IDX = MW'(DEFAULT_MASTER);
  localparam logic [TW-1:0]          TEN_MAX = TW'(MAX_TENURE);
  localparam logic [NUM_MASTERS-1:0] ONE     = NUM_MASTERS'(1);

  logic [1:0]    state;
  logic [4:0]    beat_rem;
  logic          incr_open;
  logic [TW-1:0] tenure;

  logic [4:0]    beat_rem_nxt;
  logic          incr_nxt;
  logic [TW-1:0] tenure_cnt;
  logic          lock_ok;
  logic          burst_ok;
  logic          rearb;
  logic [MW-1:0] winner;
  logic          found;
  logic          win_lock;

  // Owner index offset by 'off' positions, wrapping at NUM_MASTERS.
  function automatic logic [MW-1:0] rr_idx(input logic [MW-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % NUM_MASTERS;
    return MW'(s);
  endfunction

  assign hmastlock = (state == ST_LOCKED);

  // Burst bookkeeping as it will stand once the current beat is accepted,
  // so the last beat of a burst is itself the handover point.
  always_comb begin
    beat_rem_nxt = beat_rem;
    incr_nxt     = incr_open;
    case (htrans)
      TR_NONSEQ: begin
        incr_nxt = (hburst == BU_INCR);
        case (hburst)
          3'b010, 3'b011: beat_rem_nxt = 5'd3;
          3'b100, 3'b101: beat_rem_nxt = 5'd7;
          3'b110, 3'b111: beat_rem_nxt = 5'd15;
          default:        beat_rem_nxt = 5'd0;  // SINGLE and undefined INCR
        endcase
      end
      TR_SEQ:  beat_rem_nxt = (beat_rem == 5'd0) ? 5'd0 : beat_rem - 5'd1;
      TR_IDLE: incr_nxt = 1'b0;
      default: ;  // BUSY holds everything
    endcase
    tenure_cnt = (htrans[1] && (tenure < TEN_MAX)) ? tenure + 1'b1 : tenure;
  end

  // Re-arbitration point: lock released and no open burst (or IDLE, or tenure used up).
  always_comb begin
    lock_ok  = (state != ST_LOCKED) || !hlock[hmaster];
    burst_ok = ((beat_rem_nxt == 5'd0) && !incr_nxt) || (htrans == TR_IDLE) ||
               ((state != ST_LOCKED) && (tenure_cnt >= TEN_MAX));
    rearb    = hready && lock_ok && burst_ok;
  end

  // Round-robin scan starting after the owner; the owner itself is checked last.
  always_comb begin
    winner = DEF_IDX;
    found  = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      if (!found && hbusreq[rr_idx(hmaster, i)]) begin
        winner = rr_idx(hmaster, i);
        found  = 1'b1;
      end
    end
    win_lock = hlock[winner] & hbusreq[winner];
  end

  // Ownership, FSM and burst/tenure counters advance only on accepted cycles.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= ST_PARK;
      hmaster   <= DEF_IDX;
      hgrant    <= ONE << DEF_IDX;
      beat_rem  <= 5'd0;
      incr_open <= 1'b0;
      tenure    <= '0;
    end else if (hready) begin
      if (rearb) begin
        hmaster <= winner;
        hgrant  <= ONE << winner;
        state   <= !found ? ST_PARK : (win_lock ? ST_LOCKED : ST_OWNED);
        if (winner == hmaster) begin
          beat_rem  <= beat_rem_nxt;
          incr_open <= incr_nxt;
          tenure    <= tenure_cnt;
        end else begin
          // New owner starts with a clean burst and tenure history.
          beat_rem  <= 5'd0;
          incr_open <= 1'b0;
          tenure    <= '0;
        end
      end else begin
        beat_rem  <= beat_rem_nxt;
        incr_open <= incr_nxt;
        tenure    <= tenure_cnt;
      end
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: scenario tasks with a queue of expected bus ownership.
// Inputs are driven 1ns after a rising edge, outputs sampled 1ns after the next.
// Each expectation is queued before the edge and popped once the edge has passed.
module tb_ahb_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR   = 3'b001;
  localparam logic [2:0] INCR4  = 3'b011;

  logic       hclk = 1'b0;
  logic       hresetn;
  logic [3:0] hbusreq;
  logic [3:0] hlock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic       hmastlock;

  typedef struct packed {
    logic [1:0] m;
    logic [3:0] g;
    logic       l;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;

  ahb_arbiter #(
    .NUM_MASTERS(4), .MW(2), .DEFAULT_MASTER(0), .MAX_TENURE(16)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .hbusreq(hbusreq), .hlock(hlock),
    .htrans(htrans), .hburst(hburst), .hready(hready),
    .hgrant(hgrant), .hmaster(hmaster), .hmastlock(hmastlock)
  );

  always #5 hclk = ~hclk;

  function automatic exp_t mk(input int m, input logic l);
    exp_t x;
    x.m = 2'(m);
    x.g = 4'b0001 << m;
    x.l = l;
    return x;
  endfunction

  task automatic drive(input logic [3:0] req, input logic [3:0] lck,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
    hbusreq = req;
    hlock   = lck;
    htrans  = tr;
    hburst  = bu;
    hready  = rdy;
  endtask

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask

  task automatic test_reset;
    e = mk(0, 1'b0);
    n_checks++;
    if (hmaster !== e.m || hgrant !== e.g || hmastlock !== e.l)
      $display("FAIL reset: got m=%0d g=%b l=%b want m=%0d g=%b l=%b",
               hmaster, hgrant, hmastlock, e.m, e.g, e.l);
    else n_pass++;
  endtask

  task automatic test_round_robin;
    int seq[5] = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1);
      sb.push_back(mk(seq[i], 1'b0));
      tick();
      e = sb.pop_front();
      n_checks++;
      if (hmaster !== e.m || hgrant !== e.g || hmastlock !== e.l)
        $display("FAIL round_robin[%0d]: got m=%0d g=%b l=%b want m=%0d g=%b l=%b",
                 i, hmaster, hgrant, hmastlock, e.m, e.g, e.l);
      else n_pass++;
    end
  endtask

  task automatic test_locked;
    for (int i = 0; i < 22; i++) begin
      if (i == 0) begin
        drive(4'b1111, 4'b0100, IDLE, SINGLE, 1'b1);
        sb.push_back(mk(2, 1'b1));
      end else if (i < 21) begin
        drive(4'b1111, 4'b0100, (i == 1) ? NONSEQ : SEQ, INCR, 1'b1);
        sb.push_back(mk(2, 1'b1));
      end else begin
        drive(4'b1111, 4'b0000, IDLE, INCR, 1'b1);
        sb.push_back(mk(3, 1'b0));
      end
      tick();
      e = sb.pop_front();
      n_checks++;
      if (hmaster !== e.m || hgrant !== e.g || hmastlock !== e.l)
        $display("FAIL locked[%0d]: got m=%0d g=%b l=%b want m=%0d g=%b l=%b",
                 i, hmaster, hgrant, hmastlock, e.m, e.g, e.l);
      else n_pass++;
    end
  endtask

  task automatic test_burst_hold;
    logic [1:0] trs[7] = '{IDLE, NONSEQ, SEQ, SEQ, SEQ, SEQ, SEQ};
    logic       rdy[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int         own[7] = '{1, 1, 1, 1, 1, 1, 3};
    for (int i = 0; i < 7; i++) begin
      drive((i == 0) ? 4'b0010 : 4'b1010, 4'b0000, trs[i], INCR4, rdy[i]);
      sb.push_back(mk(own[i], 1'b0));
      tick();
      e = sb.pop_front();
      n_checks++;
      if (hmaster !== e.m || hgrant !== e.g || hmastlock !== e.l)
        $display("FAIL burst_hold[%0d]: got m=%0d g=%b l=%b want m=%0d g=%b l=%b",
                 i, hmaster, hgrant, hmastlock, e.m, e.g, e.l);
      else n_pass++;
    end
  endtask

  task automatic test_tenure;
    drive(4'b0001, 4'b0000, IDLE, INCR, 1'b1);
    sb.push_back(mk(0, 1'b0));
    tick();
    e = sb.pop_front();
    n_checks++;
    if (hmaster !== e.m || hgrant !== e.g || hmastlock !== e.l)
      $display("FAIL tenure_acquire: got m=%0d g=%b l=%b want m=%0d g=%b l=%b",
               hmaster, hgrant, hmastlock, e.m, e.g, e.l);
    else n_pass++;
    for (int beat = 1; beat <= 16; beat++) begin
      drive(4'b0011, 4'b0000, (beat == 1) ? NONSEQ : SEQ, INCR, 1'b1);
      sb.push_back(mk((beat == 16) ? 1 : 0, 1'b0));
      tick();
      e = sb.pop_front();
      n_checks++;
      if (hmaster !== e.m || hgrant !== e.g || hmastlock !== e.l)
        $display("FAIL tenure_beat%0d: got m=%0d g=%b l=%b want m=%0d g=%b l=%b",
                 beat, hmaster, hgrant, hmastlock, e.m, e.g, e.l);
      else n_pass++;
    end
  endtask

  task automatic test_parking;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        drive(4'b1000, 4'b0000, IDLE, SINGLE, 1'b1);
        sb.push_back(mk(3, 1'b0));
      end else if (i < 4) begin
        drive(4'b0000, 4'b0000, NONSEQ, SINGLE, 1'b0);
        sb.push_back(mk(3, 1'b0));
      end else if (i == 4) begin
        drive(4'b0000, 4'b0000, NONSEQ, SINGLE, 1'b1);
        sb.push_back(mk(0, 1'b0));
      end else begin
        drive(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1);
        sb.push_back(mk(0, 1'b0));
      end
      tick();
      e = sb.pop_front();
      n_checks++;
      if (hmaster !== e.m || hgrant !== e.g || hmastlock !== e.l)
        $display("FAIL parking[%0d]: got m=%0d g=%b l=%b want m=%0d g=%b l=%b",
                 i, hmaster, hgrant, hmastlock, e.m, e.g, e.l);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset;
    drive(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1);
    sb.push_back(mk(2, 1'b0));
    tick();
    e = sb.pop_front();
    n_checks++;
    if (hmaster !== e.m || hgrant !== e.g || hmastlock !== e.l)
      $display("FAIL async_reset_setup: got m=%0d g=%b l=%b want m=%0d g=%b l=%b",
               hmaster, hgrant, hmastlock, e.m, e.g, e.l);
    else n_pass++;
    #2;
    hresetn = 1'b0;
    sb.push_back(mk(0, 1'b0));
    #1;
    e = sb.pop_front();
    n_checks++;
    if (hmaster !== e.m || hgrant !== e.g || hmastlock !== e.l)
      $display("FAIL async_reset: got m=%0d g=%b l=%b want m=%0d g=%b l=%b",
               hmaster, hgrant, hmastlock, e.m, e.g, e.l);
    else n_pass++;
    #10;
    hresetn = 1'b1;
  endtask

  initial begin
    hresetn = 1'b0;
    drive(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1);
    #12;
    test_reset();
    hresetn = 1'b1;
    test_round_robin();
    test_locked();
    test_burst_hold();
    test_tenure();
    test_parking();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
